// File: rtl/iru_rot_comp_unit.sv
// Rotation compute unit: rotates a 20x20 coordinate by a one-hot 10-degree step angle
// and flags whether it stays in the window. Define IRU_COMP_PIPE_EN to register the outputs.
module iru_rot_comp_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] rnn_out,
  input  logic [4:0]  col_d,
  input  logic [4:0]  row_d,
  output logic        valid,
  output logic [4:0]  col_q,
  output logic [4:0]  row_q
);

  // Q1.7 cosine of (a * 10 degrees); sine is read from the same table shifted by 90 degrees
  function automatic logic signed [8:0] cos_lut(input logic [5:0] a);
    logic signed [8:0] v;
    case (a)
      6'd0:  v = 9'sd128;
      6'd1:  v = 9'sd126;
      6'd2:  v = 9'sd120;
      6'd3:  v = 9'sd111;
      6'd4:  v = 9'sd98;
      6'd5:  v = 9'sd82;
      6'd6:  v = 9'sd64;
      6'd7:  v = 9'sd44;
      6'd8:  v = 9'sd22;
      6'd9:  v = 9'sd0;
      6'd10: v = -9'sd22;
      6'd11: v = -9'sd44;
      6'd12: v = -9'sd64;
      6'd13: v = -9'sd82;
      6'd14: v = -9'sd98;
      6'd15: v = -9'sd111;
      6'd16: v = -9'sd120;
      6'd17: v = -9'sd126;
      6'd18: v = -9'sd128;
      6'd19: v = -9'sd126;
      6'd20: v = -9'sd120;
      6'd21: v = -9'sd111;
      6'd22: v = -9'sd98;
      6'd23: v = -9'sd82;
      6'd24: v = -9'sd64;
      6'd25: v = -9'sd44;
      6'd26: v = -9'sd22;
      6'd27: v = 9'sd0;
      6'd28: v = 9'sd22;
      6'd29: v = 9'sd44;
      6'd30: v = 9'sd64;
      6'd31: v = 9'sd82;
      6'd32: v = 9'sd98;
      6'd33: v = 9'sd111;
      6'd34: v = 9'sd120;
      6'd35: v = 9'sd126;
      default: v = 9'sd0;
    endcase
    return v;
  endfunction

  logic [5:0]         idx;
  logic [5:0]         sin_idx;
  logic signed [15:0] cos_v;
  logic signed [15:0] sin_v;
  logic signed [15:0] xs;
  logic signed [15:0] ys;
  logic signed [15:0] px;
  logic signed [15:0] py;
  logic signed [15:0] nx;
  logic signed [15:0] ny;
  logic               valid_c;
  logic [4:0]         col_c;
  logic [4:0]         row_c;

  // Downward scan so the lowest set bit is the last assignment and wins
  always_comb begin
    idx = 6'd0;
    for (int k = 35; k >= 0; k--) begin
      if (rnn_out[k]) idx = 6'(k);
    end
  end

  always_comb begin
    sin_idx = (idx >= 6'd9) ? (idx - 6'd9) : (idx + 6'd27);
    cos_v   = 16'(cos_lut(idx));
    sin_v   = 16'(cos_lut(sin_idx));
    xs      = {11'd0, col_d};
    ys      = {11'd0, row_d};
    px      = xs * cos_v - ys * sin_v;
    py      = xs * sin_v + ys * cos_v;
    nx      = px >>> 7;
    ny      = py >>> 7;
    valid_c = !nx[15] && !ny[15] && (nx < 16'sd20) && (ny < 16'sd20);
    col_c   = valid_c ? nx[4:0] : 5'd0;
    row_c   = valid_c ? ny[4:0] : 5'd0;
  end

`ifdef IRU_COMP_PIPE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      col_q <= 5'd0;
      row_q <= 5'd0;
    end else begin
      valid <= valid_c;
      col_q <= col_c;
      row_q <= row_c;
    end
  end
`else
  // Clock and reset are kept on the port list so both builds share one footprint
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};

  always_comb begin
    valid = valid_c;
    col_q = col_c;
    row_q = row_c;
  end
`endif

endmodule

// File: tb/tb_iru_rot_comp_unit.sv
// Self-checking bench for iru_rot_comp_unit; works in both the combinational and
// the IRU_COMP_PIPE_EN registered build, using a scoreboard queue of expected results.
module tb_iru_rot_comp_unit;

  logic        clk;
  logic        rst;
  logic [35:0] rnn_out;
  logic [4:0]  col_d;
  logic [4:0]  row_d;
  logic        valid;
  logic [4:0]  col_q;
  logic [4:0]  row_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [4:0] c;
    logic [4:0] r;
    string      tag;
  } exp_t;

  exp_t sb[$];

  iru_rot_comp_unit dut (
    .clk     (clk),
    .rst     (rst),
    .rnn_out (rnn_out),
    .col_d   (col_d),
    .row_d   (row_d),
    .valid   (valid),
    .col_q   (col_q),
    .row_q   (row_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference built from real trig with round-half-away and floor division
  function automatic int q7(input real v);
    if (v >= 0.0) return $rtoi($floor(v + 0.5));
    else return -$rtoi($floor(-v + 0.5));
  endfunction

  function automatic exp_t model(input logic [35:0] a, input int x, input int y, input string tag);
    exp_t e;
    int   i;
    int   cs;
    int   sn;
    int   px;
    int   py;
    int   nx;
    int   ny;
    real  ang;
    bit   found;
    i = 0;
    found = 0;
    for (int k = 0; k < 36; k++) begin
      if (!found && a[k]) begin
        i = k;
        found = 1;
      end
    end
    ang = 3.14159265358979 * real'(10 * i) / 180.0;
    cs  = q7(128.0 * $cos(ang));
    sn  = q7(128.0 * $sin(ang));
    px  = x * cs - y * sn;
    py  = x * sn + y * cs;
    nx  = $rtoi($floor(real'(px) / 128.0));
    ny  = $rtoi($floor(real'(py) / 128.0));
    e.tag = tag;
    e.v   = (nx >= 0) && (ny >= 0) && (nx < 20) && (ny < 20);
    e.c   = e.v ? 5'(nx) : 5'd0;
    e.r   = e.v ? 5'(ny) : 5'd0;
    return e;
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty got none required one entry");
    end else begin
      e = sb.pop_front();
      checks++;
      assert (valid === e.v) else begin
        errors++;
        $error("[TB] FAIL %s valid got %0b required %0b", e.tag, valid, e.v);
      end
      checks++;
      assert (col_q === e.c) else begin
        errors++;
        $error("[TB] FAIL %s col_q got %0d required %0d", e.tag, col_q, e.c);
      end
      checks++;
      assert (row_q === e.r) else begin
        errors++;
        $error("[TB] FAIL %s row_q got %0d required %0d", e.tag, row_q, e.r);
      end
    end
  endtask

  task automatic applyStimulus(input logic [35:0] a, input logic [4:0] c, input logic [4:0] r,
                               input exp_t e);
    rnn_out = a;
    col_d   = c;
    row_d   = r;
    sb.push_back(e);
`ifdef IRU_COMP_PIPE_EN
    @(posedge clk);
    #1;
`else
    #2;
`endif
    checkOutput();
  endtask

  function automatic exp_t mk(input logic v, input logic [4:0] c, input logic [4:0] r, input string tag);
    exp_t e;
    e.v = v;
    e.c = c;
    e.r = r;
    e.tag = tag;
    return e;
  endfunction

  initial begin
    rst     = 1'b1;
    rnn_out = 36'd1;
    col_d   = 5'd5;
    row_d   = 5'd7;
    @(posedge clk);
    #1;

`ifdef IRU_COMP_PIPE_EN
    sb.push_back(mk(1'b0, 5'd0, 5'd0, "reset_hold"));
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
    applyStimulus(36'd1, 5'd5, 5'd7, mk(1'b1, 5'd5, 5'd7, "post_reset_i0"));
    rst = 1'b1;
    applyStimulus(36'd1, 5'd19, 5'd19, mk(1'b0, 5'd0, 5'd0, "midstream_reset"));
    rst = 1'b0;
`else
    applyStimulus(36'd1, 5'd5, 5'd7, mk(1'b1, 5'd5, 5'd7, "rst_ignored_comb"));
    rst = 1'b0;
`endif

    applyStimulus(36'd1, 5'd5, 5'd7, mk(1'b1, 5'd5, 5'd7, "i0_5_7"));
    applyStimulus(36'd1, 5'd19, 5'd19, mk(1'b1, 5'd19, 5'd19, "i0_19_19"));
    applyStimulus(36'd1 << 9, 5'd3, 5'd0, mk(1'b1, 5'd0, 5'd3, "i9_3_0"));
    applyStimulus(36'd1 << 9, 5'd0, 5'd3, mk(1'b0, 5'd0, 5'd0, "i9_0_3"));
    applyStimulus(36'd1 << 3, 5'd10, 5'd4, mk(1'b1, 5'd6, 5'd8, "i3_10_4"));
    applyStimulus(36'd1 << 1, 5'd0, 5'd1, mk(1'b0, 5'd0, 5'd0, "i1_floor"));
    applyStimulus(36'd0, 5'd12, 5'd3, mk(1'b1, 5'd12, 5'd3, "zero_angle"));
    applyStimulus((36'd1 << 9) | (36'd1 << 18), 5'd4, 5'd0, mk(1'b1, 5'd0, 5'd4, "multi_hot"));
    applyStimulus(36'd1 << 18, 5'd1, 5'd0, mk(1'b0, 5'd0, 5'd0, "i18_neg"));
    applyStimulus(36'd1, 5'd25, 5'd2, mk(1'b0, 5'd0, 5'd0, "out_of_range_in"));

    for (int a = 0; a < 36; a++) begin
      for (int x = 0; x < 20; x++) begin
        for (int y = 0; y < 20; y++) begin
          applyStimulus(36'd1 << a, 5'(x), 5'(y), model(36'd1 << a, x, y, "sweep"));
        end
      end
    end
    for (int x = 0; x < 20; x++) begin
      for (int y = 0; y < 20; y++) begin
        applyStimulus(36'd0, 5'(x), 5'(y), model(36'd0, x, y, "sweep_zero"));
        applyStimulus((36'd1 << 9) | (36'd1 << 18), 5'(x), 5'(y),
                      model((36'd1 << 9) | (36'd1 << 18), x, y, "sweep_multi"));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iru_rot_comp_unit.md
# iru_rot_comp_unit

Rotation compute unit for the image rotation unit (IRU). It takes a one-hot angle from the rotation network (rnn_out, 36 steps of 10°) and a 20x20 pixel coordinate (col, row). It rotates the coordinate about the origin using internal cos/sin lookup tables, then reports the rotated coordinate and whether it still lies inside the 20x20 window. It sits between the RNN angle output and the IRU pixel fetch/write-back logic.

## Interface
Parameters: none (window size 20 and angle step 10° are fixed).
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- rnn_out  input  36  angle select; bit i set = rotate by i*10°
- col_d  input  5  source column (x), unsigned
- row_d  input  5  source row (y), unsigned
- valid  output  1  rotated coordinate lies in [0,20) on both axes
- col_q  output  5  rotated column; 0 when valid=0
- row_q  output  5  rotated row; 0 when valid=0

## Operation
- Angle decode:
  - Index i = position of the lowest set bit of rnn_out (priority encoder).
  - rnn_out == 0 selects i = 0 (identity).
  - Multiple set bits: the lowest index wins.
- Cos/sin LUTs (internal, 36 entries each), signed 9-bit, Q1.7 format (scale 128):
  - cos[i] = round-half-away(128*cos(10i°))
  - sin[i] = round-half-away(128*sin(10i°))
  - Reference entries (cos/sin): i=0: 128/0; i=1: 126/22; i=3: 111/64; i=6: 64/111; i=9: 0/128; i=18: -128/0; i=27: 0/-128.
- Arithmetic, x = col_d and y = row_d, zero-extended to signed:
  - px = x*cos - y*sin
  - py = x*sin + y*cos
  - Products are at least 15 bits signed; sums are at least 16 bits signed. No overflow is possible for 5-bit inputs.
  - nx = px >>> 7 and ny = py >>> 7 (arithmetic shift, floor toward -inf; e.g. -22 >>> 7 = -1).
- Validity: valid = (nx >= 0) && (ny >= 0) && (nx < 20) && (ny < 20).
- Outputs: col_q = nx[4:0] and row_q = ny[4:0] when valid; both 0 otherwise.
- Inputs 20..31 on col_d/row_d are not rejected; they are rotated by the same formula.
- The block is stateless apart from the optional output register. Each coordinate is independent and there is no handshake: a new coordinate may be applied every cycle.

## Timing
- With IRU_COMP_PIPE_EN defined: valid, col_q and row_q are registered.
  - Latency is 1 cycle: inputs sampled at edge N appear after edge N, with throughput 1 per cycle.
  - rst high at an edge forces valid=0, col_q=0, row_q=0 after that edge, overriding inputs.
  - Asserting rst mid-stream drops the in-flight result. The first result after rst deasserts corresponds to inputs sampled at the first edge with rst low.
- Without the macro: outputs are combinational from rnn_out/col_d/row_d with 0 latency. rst and clk are unused (ports retained).
- Changing rnn_out takes effect with the same latency as a coordinate change.

## Configuration
- IRU_COMP_PIPE_EN:
  - Defined: adds the output register stage, 1-cycle latency, synchronous reset to valid=0, row_q=0, col_q=0.
  - Undefined: purely combinational path, with outputs settling within the same cycle as the inputs.

## Test plan
- Reset: hold rst=1 for 2 cycles with any inputs -> valid=0, col_q=0, row_q=0; first post-reset result is correct after 1 cycle.
- i=0 (rnn_out=1<<0):
  - (x=5, y=7) -> valid=1, col 5, row 7.
  - (19,19) -> valid=1, col 19, row 19.
- i=9 (90°):
  - (3,0) -> valid=1, col 0, row 3.
  - (0,3) -> nx=-3, so valid=0, col/row 0.
- i=3 (30°), (10,4): px=854, py=1084 -> valid=1, col 6, row 8.
- Floor rounding, i=1 (10°), (0,1): px=-22 -> nx=-1, so valid=0.
- Exhaustive sweep: all 36 one-hot angles × all 400 coordinates against the formula; rnn_out=0 behaves as i=0; rnn_out=(1<<9)|(1<<18) behaves as i=9.
